rev_alu_serial: RTL

Bit-serial ALU stage built around the team's controlled-swap (Fredkin) primitive: p = ctrl, q = ctrl ? c : b, r = ctrl ? b : c. It latches two W-bit operands and an opcode on a start handshake, processes one bit per cycle LSB-first, and presents a registered result with a one-cycle done pulse. It sits directly upstream of the Fredkin select array and drives the array's operand and control inputs. Its per-bit MUX/CSWAP path is exactly that gate's q/r behaviour.

---
 rtl/rev_alu_serial.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rev_alu_serial.sv
// Bit-serial ALU stage (LSB-first) with Fredkin-style q/r select outputs.
// Optional signed-overflow output enabled by defining REV_ALU_OVF_EN.
module rev_alu_serial #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic [2:0]   op,
  input  logic         sel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res,
  output logic [W-1:0] res2,
  output logic         cout,
  output logic         zero
`ifdef REV_ALU_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_CSWAP = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_sh, b_sh;
  logic [2:0]      op_q;
  logic            sel_q;
  logic            carry;
  // Only W-1 bits are stored; the final bit is merged straight into the outputs.
  logic [W-2:0]    acc, acc2;

  logic            a_bit, b_bit, b_eff, arith;
  logic            bit_q, bit_r, carry_nx;
  logic [W-1:0]    acc_nx, acc2_nx;

  always_comb begin
    a_bit    = a_sh[0];
    b_bit    = b_sh[0];
    arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
    b_eff    = (op_q == OP_SUB) ? ~b_bit : b_bit;
    carry_nx = (a_bit & b_eff) | (a_bit & carry) | (b_eff & carry);
    bit_q    = 1'b0;
    bit_r    = a_bit;
    case (op_q)
      OP_ADD, OP_SUB: bit_q = a_bit ^ b_eff ^ carry;
      OP_AND:         bit_q = a_bit & b_bit;
      OP_OR:          bit_q = a_bit | b_bit;
      OP_XOR:         bit_q = a_bit ^ b_bit;
      OP_CSWAP: begin
        bit_q = sel_q ? b_bit : a_bit;
        bit_r = sel_q ? a_bit : b_bit;
      end
      default: begin
        bit_q = 1'b0;
        bit_r = 1'b0;
      end
    endcase
    acc_nx  = {bit_q, acc};
    acc2_nx = {bit_r, acc2};
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      op_q  <= '0;
      sel_q <= 1'b0;
      carry <= 1'b0;
      acc   <= '0;
      acc2  <= '0;
      done  <= 1'b0;
      res   <= '0;
      res2  <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
`ifdef REV_ALU_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= opa;
            b_sh  <= opb;
            op_q  <= op;
            sel_q <= sel;
            cnt   <= '0;
            carry <= (op == OP_SUB);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= {1'b0, a_sh[W-1:1]};
          b_sh  <= {1'b0, b_sh[W-1:1]};
          acc   <= acc_nx[W-1:1];
          acc2  <= acc2_nx[W-1:1];
          carry <= carry_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            res   <= acc_nx;
            res2  <= acc2_nx;
            zero  <= (acc_nx == '0);
            cout  <= arith & carry_nx;
`ifdef REV_ALU_OVF_EN
            // carry holds the carry into the MSB during the last bit.
            ovf   <= arith & (carry ^ carry_nx);
`endif
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
